// File: rtl/c17_misr_checker.sv
// Response compactor for the pipelined c17 stage: skips the stage latency, folds
// NPAT (n23,n22) pairs into a MISR and compares the final signature to GOLDEN.
module c17_misr_checker #(
  parameter int              SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'h002D,
  parameter logic [SIG_W-1:0] SEED  = {SIG_W{1'b1}},
  parameter logic [SIG_W-1:0] GOLDEN = 16'h0000,
  parameter int              NPAT   = 256,
  parameter int              LAT    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             n22,
  input  logic             n23,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature
);

  localparam int PW       = $clog2(NPAT + 1);
  localparam int LW       = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam int LAT_LAST = (LAT > 0) ? (LAT - 1) : 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_COMPACT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] w_sig_next;
  logic [SIG_W-1:0] w_misr;
  logic [PW-1:0]    r_pat_cnt;
  logic [PW-1:0]    w_pat_next;
  logic [LW-1:0]    r_lat_cnt;
  logic [LW-1:0]    w_lat_next;
  logic             r_pass;
  logic             w_pass_next;
  logic             r_busy;
  logic             r_done;

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                  input logic b1, input logic b0);
    logic [SIG_W-1:0] t;
    t = {s[SIG_W-2:0], 1'b0};
    t = t ^ (s[SIG_W-1] ? POLY : {SIG_W{1'b0}});
    t = t ^ {{(SIG_W-2){1'b0}}, b1, b0};
    return t;
  endfunction

  assign w_misr = misr_step(r_sig, n23, n22);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and next datapath values; abort outranks both start and the final update
  always_comb begin
    w_state_next = r_state;
    w_sig_next   = r_sig;
    w_pat_next   = r_pat_cnt;
    w_lat_next   = r_lat_cnt;
    w_pass_next  = r_pass;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start && !abort) begin
          w_sig_next   = SEED;
          w_pass_next  = 1'b0;
          w_pat_next   = '0;
          w_lat_next   = '0;
          w_state_next = (LAT == 0) ? ST_COMPACT : ST_FLUSH;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (abort) begin
          w_pass_next  = 1'b0;
          w_state_next = ST_IDLE;
        end else if (r_lat_cnt == LW'(LAT_LAST)) begin
          w_lat_next   = '0;
          w_state_next = ST_COMPACT;
        end else begin
          w_lat_next   = r_lat_cnt + LW'(1);
        end
      end
      ST_COMPACT: begin
        if (abort) begin
          w_pass_next  = 1'b0;
          w_state_next = ST_IDLE;
        end else begin
          w_sig_next = w_misr;
          w_pat_next = r_pat_cnt + PW'(1);
          if (r_pat_cnt == PW'(NPAT - 1)) begin
            w_pass_next  = (w_misr == GOLDEN);
            w_state_next = ST_DONE;
          end else begin
            w_state_next = ST_COMPACT;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig     <= SEED;
      r_pat_cnt <= '0;
      r_lat_cnt <= '0;
      r_pass    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_sig     <= w_sig_next;
      r_pat_cnt <= w_pat_next;
      r_lat_cnt <= w_lat_next;
      r_pass    <= w_pass_next;
      r_busy    <= (w_state_next == ST_FLUSH) || (w_state_next == ST_COMPACT);
      r_done    <= (w_state_next == ST_DONE);
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign signature = r_sig;

endmodule

// File: tb/tb_c17_misr_checker.sv
// Directed bench for c17_misr_checker: small 4-bit configurations with hand-worked
// signatures, plus a full-width run fed by a registered c17 model.
module tb_c17_misr_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Units A and B: SIG_W=4, POLY=3, SEED=F, NPAT=4, LAT=1; GOLDEN 2 and D
  logic       start_a = 1'b0, abort_a = 1'b0, n22_a = 1'b0, n23_a = 1'b0;
  logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [3:0] sig_a, sig_b;

  c17_misr_checker #(.SIG_W(4), .POLY(4'h3), .SEED(4'hF), .GOLDEN(4'h2), .NPAT(4), .LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .n22(n22_a), .n23(n23_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a));

  c17_misr_checker #(.SIG_W(4), .POLY(4'h3), .SEED(4'hF), .GOLDEN(4'hD), .NPAT(4), .LAT(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .n22(n22_a), .n23(n23_a),
    .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b));

  // Unit C: LAT=0, NPAT=1, GOLDEN=D
  logic       start_c = 1'b0, abort_c = 1'b0, n22_c = 1'b0, n23_c = 1'b0;
  logic       busy_c, done_c, pass_c;
  logic [3:0] sig_c;

  c17_misr_checker #(.SIG_W(4), .POLY(4'h3), .SEED(4'hF), .GOLDEN(4'hD), .NPAT(1), .LAT(0)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort_c), .n22(n22_c), .n23(n23_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .signature(sig_c));

  // Unit D: all defaults, fed by a one-cycle pipelined c17 stage
  logic        start_d = 1'b0, abort_d = 1'b0;
  logic [4:0]  vec = 5'd0;
  logic        st22 = 1'b0, st23 = 1'b0;
  logic        busy_d, done_d, pass_d;
  logic [15:0] sig_d;

  c17_misr_checker u_d (
    .clk(clk), .rst_n(rst_n), .start(start_d), .abort(abort_d), .n22(st22), .n23(st23),
    .busy(busy_d), .done(done_d), .pass(pass_d), .signature(sig_d));

  // c17 netlist; v = {N7,N6,N3,N2,N1}, result = {N23,N22}
  function automatic logic [1:0] c17(input logic [4:0] v);
    logic g10, g11, g16, g19;
    g10 = ~(v[0] & v[2]);
    g11 = ~(v[2] & v[3]);
    g16 = ~(v[1] & g11);
    g19 = ~(g11 & v[4]);
    return {~(g16 & g19), ~(g10 & g16)};
  endfunction

  always @(posedge clk) {st23, st22} <= c17(vec);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [3:0]  exp_sig [0:5];
  logic [15:0] ref_sig;
  logic [1:0]  r;
  logic        fb;
  int          done_at;
  logic [15:0] cap_sig;
  logic        cap_pass;

  initial begin
    // Reset values, asynchronous
    #1 rst_n = 1'b0;
    #1;
    chk("rst_sig", 32'(sig_a), 32'h0000000F);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_pass", 32'(pass_a), 32'd0);
    chk("rst_sig_d", 32'(sig_d), 32'h0000FFFF);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // All-zero responses: F(flush) F D 9 1 2
    exp_sig[0] = 4'hF; exp_sig[1] = 4'hF; exp_sig[2] = 4'hD;
    exp_sig[3] = 4'h9; exp_sig[4] = 4'h1; exp_sig[5] = 4'h2;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("z_busy0", 32'(busy_a), 32'd1);
    for (int j = 0; j < 6; j++) begin
      chk($sformatf("z_sig%0d", j), 32'(sig_a), 32'(exp_sig[j]));
      chk($sformatf("z_done%0d", j), 32'(done_a), (j == 5) ? 32'd1 : 32'd0);
      if (j < 5) @(negedge clk);
    end
    chk("z_busy_done", 32'(busy_a), 32'd0);
    chk("z_pass_a", 32'(pass_a), 32'd1);
    chk("z_pass_b", 32'(pass_b), 32'd0);
    @(negedge clk);
    chk("z_done_after", 32'(done_a), 32'd0);
    chk("z_pass_held", 32'(pass_a), 32'd1);

    // n22=1 responses: F F C A 6 D
    exp_sig[2] = 4'hC; exp_sig[3] = 4'hA; exp_sig[4] = 4'h6; exp_sig[5] = 4'hD;
    n22_a = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("o_pass_cleared", 32'(pass_a), 32'd0);
    for (int j = 0; j < 6; j++) begin
      chk($sformatf("o_sig%0d", j), 32'(sig_a), 32'(exp_sig[j]));
      if (j < 5) @(negedge clk);
    end
    chk("o_done", 32'(done_a), 32'd1);
    chk("o_pass_a", 32'(pass_a), 32'd0);
    chk("o_pass_b", 32'(pass_b), 32'd1);
    n22_a = 1'b0;
    @(negedge clk);

    // Abort in the third COMPACT cycle: signature holds 9
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("ab_sig_pre", 32'(sig_a), 32'h9);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("ab_busy", 32'(busy_a), 32'd0);
    chk("ab_sig", 32'(sig_a), 32'h9);
    chk("ab_pass_b", 32'(pass_b), 32'd0);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("ab_nodone%0d", j), 32'(done_a), 32'd0);
      @(negedge clk);
    end
    chk("ab_sig_hold", 32'(sig_a), 32'h9);

    // Start while busy is ignored; run length unchanged
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    chk("sb_sig3", 32'(sig_a), 32'h9);
    @(negedge clk);
    chk("sb_done4", 32'(done_a), 32'd0);
    @(negedge clk);
    chk("sb_done5", 32'(done_a), 32'd1);
    chk("sb_sig5", 32'(sig_a), 32'h2);
    @(negedge clk);

    // abort together with start in IDLE: not accepted
    start_a = 1'b1; abort_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; abort_a = 1'b0;
    chk("as_busy", 32'(busy_a), 32'd0);
    chk("as_sig", 32'(sig_a), 32'h2);
    chk("as_pass", 32'(pass_a), 32'd1);
    @(negedge clk);

    // Reset mid-run
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("mr_sig_pre", 32'(sig_a), 32'h9);
    rst_n = 1'b0;
    #1;
    chk("mr_sig", 32'(sig_a), 32'hF);
    chk("mr_busy", 32'(busy_a), 32'd0);
    chk("mr_done", 32'(done_a), 32'd0);
    chk("mr_pass", 32'(pass_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_stay_idle", 32'(busy_a), 32'd0);

    // LAT=0, NPAT=1, start held: done every second cycle
    start_c = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 6; j++) begin
      chk($sformatf("bb_done%0d", j), 32'(done_c), (j % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("bb_sig%0d", j), 32'(sig_c), (j % 2 == 1) ? 32'hD : 32'hF);
      chk($sformatf("bb_busy%0d", j), 32'(busy_c), (j % 2 == 1) ? 32'd0 : 32'd1);
      if (j % 2 == 1) chk($sformatf("bb_pass%0d", j), 32'(pass_c), 32'd1);
      else            chk($sformatf("bb_pass%0d", j), 32'(pass_c), 32'd0);
      @(negedge clk);
    end
    start_c = 1'b0;
    @(negedge clk);

    // Full-width run against the c17 stage, exhaustive 32-vector repeat
    ref_sig = 16'hFFFF;
    for (int m = 0; m < 256; m++) begin
      r  = c17(5'(m % 32));
      fb = ref_sig[15];
      ref_sig = {ref_sig[14:0], 1'b0};
      if (fb) ref_sig = ref_sig ^ 16'h002D;
      ref_sig[0] = ref_sig[0] ^ r[0];
      ref_sig[1] = ref_sig[1] ^ r[1];
    end
    done_at  = -1;
    cap_sig  = 16'h0000;
    cap_pass = 1'b0;
    start_d = 1'b1;
    @(negedge clk);
    start_d = 1'b0;
    for (int j = 0; j < 300; j++) begin
      vec = 5'(j);
      if (done_d === 1'b1 && done_at < 0) begin
        done_at  = j;
        cap_sig  = sig_d;
        cap_pass = pass_d;
      end
      @(negedge clk);
    end
    chk("fw_done_at", 32'(done_at), 32'd257);
    chk("fw_sig", 32'(cap_sig), 32'(ref_sig));
    chk("fw_pass", 32'(cap_pass), (ref_sig == 16'h0000) ? 32'd1 : 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
